// File: rtl/reverb_pkg.sv
// Shared constants and types for the reverb parameter control path.
package reverb_pkg;

  localparam int DATA_W = 24;

  localparam logic [3:0] P_PREDELAY = 4'b0001;
  localparam logic [3:0] P_DECAY    = 4'b0010;
  localparam logic [3:0] P_DAMPING  = 4'b0100;
  localparam logic [3:0] P_MIX      = 4'b1000;

  localparam logic [1:0] UPD_IDLE = 2'b00;
  localparam logic [1:0] UPD_INC  = 2'b01;
  localparam logic [1:0] UPD_DEC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } param_state_t;

endpackage

// File: rtl/reverb_param_shadow.sv
// Four-value shadow bank; copies all inputs together on a sample tick so the
// datapath only ever sees coefficient changes on sample boundaries.
module reverb_param_shadow #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] predelay_in,
  input  logic [DATA_W-1:0] decay_in,
  input  logic [DATA_W-1:0] damping_in,
  input  logic [DATA_W-1:0] mix_in,
  output logic [DATA_W-1:0] predelay_out,
  output logic [DATA_W-1:0] decay_out,
  output logic [DATA_W-1:0] damping_out,
  output logic [DATA_W-1:0] mix_out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      predelay_out <= '0;
      decay_out    <= '0;
      damping_out  <= '0;
      mix_out      <= '0;
    end else if (tick) begin
      predelay_out <= predelay_in;
      decay_out    <= decay_in;
      damping_out  <= damping_in;
      mix_out      <= mix_in;
    end
  end

endmodule

// File: rtl/reverb_param_ctrl.sv
// Front-panel edit sequencer: queues encoder steps, presents them to the HPS as
// held update codes, and re-times returned parameter values onto sample ticks.
module reverb_param_ctrl #(
  parameter int HOLD_CYCLES = 1024,
  parameter int GAP_CYCLES  = 256,
  parameter int DATA_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              enc_inc,
  input  logic              enc_dec,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] predelay_in,
  input  logic [DATA_W-1:0] decay_in,
  input  logic [DATA_W-1:0] damping_in,
  input  logic [DATA_W-1:0] mix_in,
  output logic [3:0]        param_type,
  output logic [1:0]        param_update,
  output logic [DATA_W-1:0] predelay_out,
  output logic [DATA_W-1:0] decay_out,
  output logic [DATA_W-1:0] damping_out,
  output logic [DATA_W-1:0] mix_out,
  output logic              busy
);

  import reverb_pkg::*;

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  function automatic logic signed [3:0] sat_pending(input logic signed [4:0] v);
    if (v > 5'sd7)
      return 4'sd7;
    else if (v < -5'sd7)
      return -4'sd7;
    else
      return 4'(v);
  endfunction

  param_state_t       state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic signed [3:0]  pending, pending_n;
  logic signed [4:0]  enc_delta, use_delta;
  logic [1:0]         upd_n;
  logic [3:0]         sel_n;
  logic               busy_n;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    upd_n     = param_update;
    use_delta = 5'sd0;
    enc_delta = 5'sd0;
    sel_n     = param_type;

    case (state)
      ST_IDLE: begin
        if (pending > 4'sd0) begin
          upd_n     = UPD_INC;
          use_delta = -5'sd1;
          cnt_n     = HOLD_LOAD;
          state_n   = ST_HOLD;
        end else if (pending < 4'sd0) begin
          upd_n     = UPD_DEC;
          use_delta = 5'sd1;
          cnt_n     = HOLD_LOAD;
          state_n   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          upd_n   = UPD_IDLE;
          cnt_n   = GAP_LOAD;
          state_n = ST_GAP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0)
          state_n = ST_IDLE;
        else
          cnt_n = cnt - 1'b1;
      end
      default: begin
        upd_n   = UPD_IDLE;
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase

    // Consume and new encoder steps land in one saturated update.
    if (enc_inc && !enc_dec)
      enc_delta = 5'sd1;
    else if (enc_dec && !enc_inc)
      enc_delta = -5'sd1;
    pending_n = sat_pending(5'(pending) + enc_delta + use_delta);

    busy_n = (state_n != ST_IDLE) || (pending_n != 4'sd0);

    // Selection is frozen while edits are queued or in flight.
    if (!busy && (btn_next ^ btn_prev)) begin
      if (btn_next)
        sel_n = {param_type[2:0], param_type[3]};
      else
        sel_n = {param_type[0], param_type[3:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      pending      <= 4'sd0;
      param_update <= UPD_IDLE;
      param_type   <= P_PREDELAY;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pending      <= pending_n;
      param_update <= upd_n;
      param_type   <= sel_n;
      busy         <= busy_n;
    end
  end

  reverb_param_shadow #(
    .DATA_W(DATA_W)
  ) u_shadow (
    .clk          (clk),
    .reset        (reset),
    .tick         (sample_tick),
    .predelay_in  (predelay_in),
    .decay_in     (decay_in),
    .damping_in   (damping_in),
    .mix_in       (mix_in),
    .predelay_out (predelay_out),
    .decay_out    (decay_out),
    .damping_out  (damping_out),
    .mix_out      (mix_out)
  );

endmodule
